// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
//
// Word-level front/back end for a one-bit serial adder stage. It accepts a pair
// of W-bit operands on a valid/ready handshake, clears the external adder,
// streams both operands LSB-first one bit per clock, then gathers the adder's
// registered sum bits and final carry into a parallel result. The result is
// offered on a valid/ready handshake.
//
// Ports:
//   clk        single clock, all state updates on its rising edge
//   r          synchronous active-high reset
//   in_valid   operand pair op_a/op_b is valid
//   in_ready   block can accept an operand pair (IDLE only)
//   op_a/op_b  W-bit operands
//   a_bit      serial A bit to the adder's a input
//   b_bit      serial B bit to the adder's b input
//   add_clr    drives the adder's reset input (clears its sum/carry)
//   s_in       adder's registered sum output
//   c_in       adder's carry output
//   out_valid  result/carry_out are valid (DONE only)
//   out_ready  consumer accepts the result
//   result     (op_a + op_b) mod 2^W
//   carry_out  carry out of bit W-1
// -----------------------------------------------------------------------------
module serial_add_ctrl #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         r,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    output logic         a_bit,
    output logic         b_bit,
    output logic         add_clr,
    input  logic         s_in,
    input  logic         c_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         carry_out
);

    localparam int CNT_W = $clog2(W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(W - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        SHIFT,
        DRAIN,
        DONE
    } state_t;

    state_t           r_state;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [W-1:0]     r_result;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;

    // Sum bits arrive one cycle late (the adder registers them), so each
    // capture shifts the newest bit in at the MSB; after W captures bit s_0
    // has walked down to result[0].
    logic [W-1:0]     w_result_shifted;
    assign w_result_shifted = {s_in, r_result[W-1:1]};

    always_ff @(posedge clk) begin
        if (r) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a      <= op_a;
                        r_b      <= op_b;
                        r_result <= '0;
                        r_cnt    <= '0;
                        r_state  <= CLR;
                    end
                end
                CLR: begin
                    r_state <= SHIFT;
                end
                SHIFT: begin
                    r_a <= r_a >> 1;
                    r_b <= r_b >> 1;
                    // During SHIFT cycle 0 the adder's s output still holds
                    // the cleared value, so the first real sum bit is only
                    // available from cycle 1 on.
                    if (r_cnt != '0) begin
                        r_result <= w_result_shifted;
                    end
                    if (r_cnt == LAST_BIT) begin
                        r_state <= DRAIN;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    // Last sum bit and the carry out of bit W-1 are both
                    // registered by the adder at the close of the final SHIFT.
                    r_result <= w_result_shifted;
                    r_carry  <= c_in;
                    r_state  <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Outputs decode straight from state registers; add_clr also follows r so
    // the adder is cleared for as long as the controller is held in reset.
    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign a_bit     = (r_state == SHIFT) ? r_a[0] : 1'b0;
    assign b_bit     = (r_state == SHIFT) ? r_b[0] : 1'b0;
    assign add_clr   = r | (r_state == CLR);
    assign result    = r_result;
    assign carry_out = r_carry;

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Word-level front/back end for the one-bit serial adder stage.
- Accepts two W-bit parallel operands on a valid/ready handshake and clears the adder.
- Streams the operands LSB-first on a_bit/b_bit, one bit per clk.
- Collects the adder's registered sum bits and final carry into a W-bit parallel result, offered on a valid/ready handshake.

Parameters:
W, 8, operand/result width in bits; legal range W >= 2.

Ports:
clk  input  1  single clock; all state updates on posedge clk
r  input  1  reset, synchronous, active-high
in_valid  input  1  op_a/op_b valid
in_ready  output  1  block can accept operands
op_a  input  W  operand A
op_b  input  W  operand B
a_bit  output  1  serial A bit to adder input a
b_bit  output  1  serial B bit to adder input b
add_clr  output  1  to adder reset input r; clears adder sum/carry
s_in  input  1  adder registered sum output s
c_in  input  1  adder carry output c
out_valid  output  1  result/carry_out valid
out_ready  input  1  consumer accepts result
result  output  W  A+B mod 2^W
carry_out  output  1  carry out of bit W-1

Behaviour:
- All outputs are decoded from registers, with no combinational path from inputs to outputs.
- add_clr is the only exception: add_clr = r OR (state==CLR).
- Reset (r=1 at posedge):
  - state=IDLE; shift regs, bit counter, result, carry_out all 0.
  - Resulting outputs: in_ready=1, out_valid=0, a_bit=b_bit=0, add_clr=1 while r is high.
- States: IDLE, CLR, SHIFT, DRAIN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch op_a/op_b into shift regs, clear result, count=0, go to CLR.
- CLR (exactly 1 cycle):
  - add_clr=1, a_bit=b_bit=0; the adder clears its carry at the closing edge.
  - Go to SHIFT.
- SHIFT (exactly W cycles, count 0..W-1):
  - a_bit=A[count], b_bit=B[count] (LSB of the shift regs); shift regs shift right each cycle.
  - The adder registers sum bit s_i at the close of SHIFT cycle i, so s_in carries s_(i-1) during SHIFT cycle i, for i>=1.
  - At the close of SHIFT cycles 1..W-1: result <= {s_in, result[W-1:1]}.
  - At the close of cycle count==W-1: go to DRAIN.
- DRAIN (1 cycle):
  - a_bit=b_bit=0, add_clr=0.
  - Capture: result <= {s_in, result[W-1:1]}; carry_out <= c_in (carry of bit W-1).
  - Go to DONE.
- DONE:
  - out_valid=1; result/carry_out held stable.
  - On out_ready: go to IDLE; out_valid drops the next cycle.
- Handshakes:
  - in_ready is high only in IDLE.
  - in_valid outside IDLE is ignored; operands are not queued.
  - out_valid is held with data stable until out_ready is sampled high.
- Latency:
  - out_valid rises W+2 cycles after the accepting edge.
  - Minimum initiation interval is W+4 cycles (handshake, CLR, W shift, DRAIN, DONE).
- a_bit/b_bit are 0 in every state other than SHIFT.
- Arithmetic: result = (op_a+op_b) mod 2^W; carry_out = bit W of op_a+op_b.
- Reset mid-operation (any state): abort immediately and return to the reset values.
  - add_clr is asserted during reset, so the adder is cleared too.
  - No out_valid is produced for the aborted word.
- Simultaneous out_ready in DONE and in_valid: the new operand is accepted only in the following IDLE cycle.
- Counter width: $clog2(W); wrap-around is not used (the counter is cleared on accept).

Test Plan:
- W=8, op_a=0x5A, op_b=0x3C, out_ready=1 -> add_clr pulse for 1 cycle after accept; a_bit sequence 0,1,0,1,1,0,1,0; result=0x96, carry_out=0; out_valid 10 cycles after accept.
- op_a=0xFF, op_b=0x01 -> result=0x00, carry_out=1. Follow with op_a=0x01, op_b=0x01 -> result=0x02, carry_out=0 (carry cleared by CLR).
- Hold out_ready=0 for 5 cycles in DONE with 0x80+0x80 -> out_valid and result=0x00, carry_out=1 stable; in_ready=0 throughout; in_valid pulses ignored.
- Assert r for 1 cycle in SHIFT cycle 3 of 0x0F+0x0F -> next cycle IDLE, in_ready=1, out_valid=0, add_clr=1 during r. Then 0x0F+0x0F -> result=0x1E, carry_out=0.
- Back-to-back in_valid held high with out_ready=1 -> accepts spaced exactly W+4 cycles apart; no dropped or duplicated results.
- 200 random operand pairs with random out_ready stalls -> {carry_out,result} equals op_a+op_b for each pair, in order.
